// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two cache miss requesters, the arbiter and main memory.
// slave = arbiter view; master = requester/memory environment view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              dirty0, dirty1;
  logic [ADDR_W-1:0] vaddr0, vaddr1;
  logic [LINE_W-1:0] wdata0, wdata1;
  logic              done0, done1;
  logic [LINE_W-1:0] rdata0, rdata1;
  logic              busy;
  logic              mem_re, mem_we;
  logic [ADDR_W-5:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, addr0, addr1, dirty0, dirty1, vaddr0, vaddr1, wdata0, wdata1, mem_rdata,
    output done0, done1, rdata0, rdata1, busy, mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, addr0, addr1, dirty0, dirty1, vaddr0, vaddr1, wdata0, wdata1, mem_rdata,
    input  done0, done1, rdata0, rdata1, busy, mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter giving two cache miss ports access to one 128-bit memory:
// optional dirty-victim writeback, then line fill, then a one-cycle done pulse.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int MEM_LAT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);
  localparam int CW   = $clog2(MEM_LAT + 1);
  localparam int LA_W = ADDR_W - 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic              port_q, port_d;
  logic [LA_W-1:0]   addr_q, addr_d;
  logic [LA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0] rdata0_q, rdata0_d;
  logic [LINE_W-1:0] rdata1_q, rdata1_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              gnt;
  logic              unused_lsbs;

  assign unused_lsbs = ^{bus.addr0[3:0], bus.addr1[3:0], bus.vaddr0[3:0], bus.vaddr1[3:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    port_d      = port_q;
    addr_d      = addr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    // Contention goes to rr_q; otherwise to whichever single port is asking.
    gnt = (bus.req0 && bus.req1) ? rr_q : bus.req1;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          port_d = gnt;
          cnt_d  = '0;
          addr_d = gnt ? bus.addr1[ADDR_W-1:4] : bus.addr0[ADDR_W-1:4];
          if (gnt ? bus.dirty1 : bus.dirty0) begin
            state_d     = WB;
            mem_we_d    = 1'b1;
            mem_addr_d  = gnt ? bus.vaddr1[ADDR_W-1:4] : bus.vaddr0[ADDR_W-1:4];
            mem_wdata_d = gnt ? bus.wdata1 : bus.wdata0;
          end else begin
            state_d    = FILL;
            mem_re_d   = 1'b1;
            mem_addr_d = addr_d;
          end
        end
      end
      WB: begin
        if (cnt_q == CNT_LAST) begin
          state_d    = FILL;
          cnt_d      = '0;
          mem_re_d   = 1'b1;
          mem_addr_d = addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FILL: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          // Line is captured straight into the winner's rdata so it is valid with done.
          if (port_q) begin
            rdata1_d = bus.mem_rdata;
            done1_d  = 1'b1;
          end else begin
            rdata0_d = bus.mem_rdata;
            done0_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        rr_d    = ~port_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      port_q      <= 1'b0;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      port_q      <= port_d;
      addr_q      <= addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
    end
  end

  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule
